crc_decoder: RTL and testbench
==============================

CRC_DECODER -- requirements
Module: crc_decoder

Interface
REQ-001 SHALL provide: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL provide: reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-003 SHALL provide: in_sof  input  1  marks the first codeword bit, qualified by in_valid.
REQ-004 SHALL provide: in_bit  input  1  serial codeword bit, MSB (coefficient x^6) first.
REQ-005 SHALL provide: in_valid  input  1  in_bit/in_sof valid this cycle.
REQ-006 SHALL provide: in_ready  output  1  decoder accepts a bit this cycle.
REQ-007 SHALL provide: data_out  output  4  recovered data bits (codeword bits 6..3).
REQ-008 SHALL provide: crc_err  output  1  nonzero syndrome for the held codeword.
REQ-009 SHALL provide: syndrome  output  3  remainder of received codeword mod g(x).
REQ-010 SHALL provide: corrected  output  1  single-bit correction applied (see REQ-031).
REQ-011 SHALL provide: out_valid  output  1  result held and valid.
REQ-012 SHALL provide: out_ready  input  1  consumer accepts result when out_valid is high.

Function
REQ-013 Code SHALL be cyclic (7,4) with generator g(x)=x^3+x+1 (1011), systematic: codeword = data[3:0] followed by 3 check bits.
REQ-014 A bit SHALL be accepted only when in_valid and in_ready are both high.
REQ-015 FSM states SHALL be IDLE, RECV, HOLD; reset state IDLE.
REQ-016 IDLE: in_ready=1; accepted bit with in_sof=1 -> RECV with count=1; accepted bit with in_sof=0 dropped, stay IDLE.
REQ-017 RECV: in_ready=1; each accepted bit increments 3-bit count; 7th accepted bit -> HOLD.
REQ-018 RECV: accepted bit with in_sof=1 SHALL abort the current frame and restart it as bit 1 (count=1, remainder recomputed from that bit).
REQ-019 Remainder update per accepted bit: rem_next = {rem[1:0], in_bit} XOR (rem[2] ? 3'b011 : 3'b000); rem cleared on frame start before the first bit is shifted.
REQ-020 Codeword bits SHALL also be captured in a 7-bit shift register.
REQ-021 HOLD: in_ready=0; out_valid=1; data_out, syndrome, crc_err, corrected stable until out_ready=1.
REQ-022 out_valid SHALL rise the cycle after the 7th bit is accepted (latency 1 cycle).
REQ-023 HOLD with out_ready=1 -> IDLE next cycle; no same-cycle input bypass (one-cycle bubble between frames).
REQ-024 crc_err SHALL equal (syndrome != 0); outputs other than out_valid are don't-care outside HOLD but SHALL be driven to 0.
REQ-025 in_valid low cycles within RECV SHALL stall without changing state or count.

Reset
REQ-026 reset SHALL force state=IDLE, count=0, rem=0, shift register=0.
REQ-027 After reset: in_ready=1, out_valid=0, data_out=0, syndrome=0, crc_err=0, corrected=0.
REQ-028 Reset asserted mid-frame or in HOLD SHALL discard the frame; no out_valid produced for it.
REQ-029 reset SHALL take priority over all other inputs in the same cycle.

Configuration
REQ-030 Macro CRC_CORRECT_EN SHALL select single-bit error correction.
REQ-031 Defined: syndrome maps to error position (001->x^0, 010->x^1, 100->x^2, 011->x^3, 110->x^4, 111->x^5, 101->x^6); flipped bit inverted before data_out; corrected=1 when syndrome!=0; crc_err still reports raw syndrome.
REQ-032 Not defined: data_out = raw received bits 6..3; corrected tied 0; no correction logic present.

Verification
REQ-033 Bits 1010011 (sof on first) -> out_valid after 7th bit +1 cycle, data_out=1010, syndrome=000, crc_err=0.
REQ-034 Frames 1101001, 0011101, 1111111 back-to-back with out_ready=1 -> data 1101/0011/1111, crc_err=0 each, one bubble cycle between frames.
REQ-035 Bits 0010011 (x^6 flipped) -> syndrome=101, crc_err=1; with CRC_CORRECT_EN data_out=1010, corrected=1; without data_out=0010, corrected=0.
REQ-036 out_ready held 0 for 5 cycles in HOLD -> outputs stable, in_ready=0, bits offered are not consumed.
REQ-037 reset pulsed after 4 bits of 1010011, then full 1101001 sent -> single out_valid, data_out=1101, crc_err=0.
REQ-038 sof re-asserted at bit 3 of a frame, then full 0011101 from that bit -> data_out=0011, crc_err=0; in_valid gaps inserted mid-frame give identical result.

Source files
------------

// File: rtl/crc_decoder.sv
// Serial (7,4) cyclic-code decoder, g(x)=x^3+x+1, MSB first, with a valid/ready handshake on both sides.
// Define CRC_CORRECT_EN to enable single-bit error correction of the held codeword.
module crc_decoder (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_sof,
  input  logic       in_bit,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [3:0] data_out,
  output logic       crc_err,
  output logic [2:0] syndrome,
  output logic       corrected,
  output logic       out_valid,
  input  logic       out_ready
);

  typedef enum logic [1:0] {IDLE, RECV, HOLD} state_t;

  state_t     state, state_next;
  logic [2:0] count;
  logic [2:0] rem;
  logic [2:0] rem_next;
  logic [6:0] shreg;
  logic [6:0] fixed;
  logic       fix_flag;
  logic       accept;
  logic       frame_start;

  assign accept      = in_valid && in_ready;
  assign frame_start = accept && in_sof;
  assign rem_next    = {rem[1:0], in_bit} ^ (rem[2] ? 3'b011 : 3'b000);

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (frame_start) state_next = RECV;
      RECV:    if (accept && !in_sof && count == 3'd6) state_next = HOLD;
      HOLD:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A start-of-frame bit restarts the frame from a cleared remainder, even mid-frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= 3'd0;
      rem   <= 3'd0;
      shreg <= 7'd0;
    end else if (frame_start) begin
      count <= 3'd1;
      rem   <= {2'b00, in_bit};
      shreg <= {6'd0, in_bit};
    end else if (accept && state == RECV) begin
      count <= count + 3'd1;
      rem   <= rem_next;
      shreg <= {shreg[5:0], in_bit};
    end
  end

`ifdef CRC_CORRECT_EN
  logic [6:0] err_mask;

  // Syndrome of a single error at x^k equals x^k mod g(x).
  always_comb begin
    err_mask = 7'd0;
    case (rem)
      3'b001:  err_mask = 7'b0000001;
      3'b010:  err_mask = 7'b0000010;
      3'b100:  err_mask = 7'b0000100;
      3'b011:  err_mask = 7'b0001000;
      3'b110:  err_mask = 7'b0010000;
      3'b111:  err_mask = 7'b0100000;
      3'b101:  err_mask = 7'b1000000;
      default: err_mask = 7'd0;
    endcase
  end

  assign fixed    = shreg ^ err_mask;
  assign fix_flag = (rem != 3'd0);
`else
  assign fixed    = shreg;
  assign fix_flag = 1'b0;
`endif

  always_comb begin
    in_ready  = (state != HOLD);
    out_valid = 1'b0;
    data_out  = 4'd0;
    syndrome  = 3'd0;
    crc_err   = 1'b0;
    corrected = 1'b0;
    if (state == HOLD) begin
      out_valid = 1'b1;
      data_out  = fixed[6:3];
      syndrome  = rem;
      crc_err   = (rem != 3'd0);
      corrected = fix_flag;
    end
  end

endmodule

// File: tb/tb_crc_decoder.sv
// Self-checking bench for crc_decoder: directed vector table, corner-case sequences and
// randomized frames checked against a polynomial-division reference model.
module tb_crc_decoder;

  logic       clk = 1'b0;
  logic       reset, in_sof, in_bit, in_valid, out_ready;
  logic       in_ready, crc_err, corrected, out_valid;
  logic [3:0] data_out;
  logic [2:0] syndrome;

  int checks   = 0;
  int failures = 0;
  int bubbles  = 0;

  crc_decoder dut (
    .clk      (clk),
    .reset    (reset),
    .in_sof   (in_sof),
    .in_bit   (in_bit),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .data_out (data_out),
    .crc_err  (crc_err),
    .syndrome (syndrome),
    .corrected(corrected),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] cw;
    logic [3:0] data;
    logic [2:0] syn;
    logic       err;
    logic       corr;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Remainder of cw(x) mod x^3+x+1 by long division.
  function automatic logic [2:0] model_syn(input logic [6:0] cw);
    logic [6:0] r;
    r = cw;
    for (int i = 6; i >= 3; i--)
      if (r[i]) r = r ^ (7'b0001011 << (i - 3));
    return r[2:0];
  endfunction

  function automatic logic [3:0] model_data(input logic [6:0] cw);
    logic [6:0] w;
    w = cw;
`ifdef CRC_CORRECT_EN
    if (model_syn(cw) != 3'd0)
      for (int j = 0; j < 7; j++)
        if (model_syn(7'(1 << j)) == model_syn(cw)) w = cw ^ 7'(1 << j);
`endif
    return w[6:3];
  endfunction

  function automatic logic model_corr(input logic [6:0] cw);
`ifdef CRC_CORRECT_EN
    return model_syn(cw) != 3'd0;
`else
    return (cw == 7'd0) && (cw != 7'd0);
`endif
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // Offers the 7 bits (sof on the first); waits out in_ready=0 cycles, counting them as bubbles.
  task automatic send_frame(input logic [6:0] cw, input int gap_pct);
    int guard;
    for (int i = 0; i < 7; i++) begin
      if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        in_valid = 1'b0;
        step();
      end
      in_valid = 1'b1;
      in_sof   = (i == 0);
      in_bit   = cw[6 - i];
      guard    = 0;
      while (!in_ready && guard < 20) begin
        bubbles++;
        guard++;
        step();
      end
      if (guard >= 20) check("in_ready_timeout", 32'(in_ready), 32'd1);
      if (i == 6) check("out_valid_before_last", 32'(out_valid), 32'd0);
      step();
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic check_result(input string name, input logic [3:0] data, input logic [2:0] syn,
                              input logic err, input logic corr);
    check({name, "_out_valid"}, 32'(out_valid), 32'd1);
    check({name, "_data"},      32'(data_out),  32'(data));
    check({name, "_syndrome"},  32'(syndrome),  32'(syn));
    check({name, "_crc_err"},   32'(crc_err),   32'(err));
    check({name, "_corrected"}, 32'(corrected), 32'(corr));
  endtask

  task automatic check_model(input string name, input logic [6:0] cw);
    check_result(name, model_data(cw), model_syn(cw), model_syn(cw) != 3'd0, model_corr(cw));
  endtask

  task automatic release_result(input string name);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({name, "_released"}, 32'(out_valid), 32'd0);
    check({name, "_ready_again"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] held_data;
    logic [2:0] held_syn;
    logic [6:0] cw;
    logic [3:0] d;

    vecs[0] = '{7'b1010011, 4'b1010, 3'b000, 1'b0, 1'b0};
    vecs[1] = '{7'b1101001, 4'b1101, 3'b000, 1'b0, 1'b0};
    vecs[2] = '{7'b0011101, 4'b0011, 3'b000, 1'b0, 1'b0};
    vecs[3] = '{7'b1111111, 4'b1111, 3'b000, 1'b0, 1'b0};
    vecs[4] = '{7'b0000000, 4'b0000, 3'b000, 1'b0, 1'b0};
`ifdef CRC_CORRECT_EN
    vecs[5] = '{7'b0010011, 4'b1010, 3'b101, 1'b1, 1'b1};
`else
    vecs[5] = '{7'b0010011, 4'b0010, 3'b101, 1'b1, 1'b0};
`endif

    reset = 1'b0; in_sof = 1'b0; in_bit = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    do_reset();
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_data",      32'(data_out),  32'd0);
    check("rst_syndrome",  32'(syndrome),  32'd0);
    check("rst_crc_err",   32'(crc_err),   32'd0);
    check("rst_corrected", 32'(corrected), 32'd0);

    // Directed vector table.
    foreach (vecs[i]) begin
      send_frame(vecs[i].cw, 0);
      check_result($sformatf("vec%0d", i), vecs[i].data, vecs[i].syn, vecs[i].err, vecs[i].corr);
      release_result($sformatf("vec%0d", i));
    end

    // Bits without sof in IDLE are dropped.
    in_valid = 1'b1; in_sof = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_bit = 1'b1;
      step();
    end
    in_valid = 1'b0;
    check("idle_drop_no_valid", 32'(out_valid), 32'd0);
    send_frame(7'b1010011, 0);
    check_result("idle_drop", 4'b1010, 3'b000, 1'b0, 1'b0);
    release_result("idle_drop");

    // Back-to-back frames with out_ready held high: one bubble between frames.
    out_ready = 1'b1;
    bubbles   = 0;
    send_frame(7'b1101001, 0);
    check_result("b2b0", 4'b1101, 3'b000, 1'b0, 1'b0);
    send_frame(7'b0011101, 0);
    check_result("b2b1", 4'b0011, 3'b000, 1'b0, 1'b0);
    send_frame(7'b1111111, 0);
    check_result("b2b2", 4'b1111, 3'b000, 1'b0, 1'b0);
    check("b2b_bubbles", 32'(bubbles), 32'd2);
    step();
    out_ready = 1'b0;
    check("b2b_done", 32'(out_valid), 32'd0);

    // HOLD stalls while out_ready is low; offered bits are not consumed.
    send_frame(7'b0010011, 0);
    held_data = data_out;
    held_syn  = syndrome;
    in_valid = 1'b1; in_sof = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_bit = 1'($urandom_range(1));
      step();
      check("hold_in_ready",  32'(in_ready),  32'd0);
      check("hold_out_valid", 32'(out_valid), 32'd1);
      check("hold_data",      32'(data_out),  32'(held_data));
      check("hold_syndrome",  32'(syndrome),  32'(held_syn));
    end
    in_valid = 1'b0; in_sof = 1'b0;
    check_model("hold_final", 7'b0010011);
    release_result("hold");
    for (int i = 0; i < 8; i++) step();
    check("hold_not_consumed", 32'(out_valid), 32'd0);

    // Reset mid-frame (with competing sof) discards the frame.
    in_valid = 1'b1;
    cw = 7'b1010011;
    for (int i = 0; i < 4; i++) begin
      in_sof = (i == 0);
      in_bit = cw[6 - i];
      step();
    end
    reset = 1'b1; in_sof = 1'b1; in_bit = 1'b1;
    step();
    reset = 1'b0; in_valid = 1'b0; in_sof = 1'b0;
    check("midrst_in_ready",  32'(in_ready),  32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    send_frame(7'b1101001, 0);
    check_result("midrst", 4'b1101, 3'b000, 1'b0, 1'b0);
    release_result("midrst");
    for (int i = 0; i < 10; i++) step();
    check("midrst_single", 32'(out_valid), 32'd0);

    // Reset while holding a result drops it.
    send_frame(7'b1111111, 0);
    check("holdrst_pre", 32'(out_valid), 32'd1);
    out_ready = 1'b0;
    do_reset();
    check("holdrst_out_valid", 32'(out_valid), 32'd0);
    check("holdrst_data",      32'(data_out),  32'd0);

    // sof re-asserted at bit 3 restarts the frame, with and without in_valid gaps.
    for (int g = 0; g < 2; g++) begin
      in_valid = 1'b1;
      in_sof = 1'b1; in_bit = 1'b1; step();
      in_sof = 1'b0; in_bit = 1'b0; step();
      send_frame(7'b0011101, g * 40);
      check_result($sformatf("resof%0d", g), 4'b0011, 3'b000, 1'b0, 1'b0);
      release_result($sformatf("resof%0d", g));
    end

    // Randomized frames against the reference model.
    for (int n = 0; n < 40; n++) begin
      d  = 4'($urandom_range(15));
      cw = {d, 3'b000};
      cw = cw | {4'b0000, model_syn(cw)};
      if ($urandom_range(1) == 1) cw = cw ^ 7'(1 << $urandom_range(6));
      if ($urandom_range(3) == 0) cw = 7'($urandom_range(127));
      send_frame(cw, int'($urandom_range(30)));
      check_model($sformatf("rand%0d", n), cw);
      for (int w = 0; w < int'($urandom_range(2)); w++) step();
      release_result($sformatf("rand%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
